// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_pkg
// Purpose : Shared constants for the sequential ALU: opcode encodings, flag
//           bit positions inside the {N,Z,V,C} flag word, FSM state codes
//           and the active-low seven-segment glyph table.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // Opcodes; 0xD..0xF all decode as PASS A, OP_PASS names the first of them.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_DEC  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ASR  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;

  // Bit positions inside the flag word {N,Z,V,C}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MULT = 1'b1;

  // Active-low segments {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_if
// Purpose : Request/response bundle of the sequential ALU.
// Ports   : in_valid/in_ready handshake, op, a, b, use_acc (request side);
//           out_valid, result, flags {N,Z,V,C}, hex (response side).
//           master = stimulus side, slave = ALU side.
// Rev     : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int W    = 8,
  parameter int NDIG = W / 4
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               use_acc;
  logic               out_valid;
  logic [W-1:0]       result;
  logic [3:0]         flags;
  logic [7*NDIG-1:0]  hex;

  modport master (
    output in_valid, op, a, b, use_acc,
    input  in_ready, out_valid, result, flags, hex
  );

  modport slave (
    input  in_valid, op, a, b, use_acc,
    output in_ready, out_valid, result, flags, hex
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_hex7seg.sv
`default_nettype none
// ============================================================================
// Module  : hex7seg
// Purpose : Combinational 4-bit to active-low seven-segment decoder.
// Ports   : nib  in  4  hex nibble
//           seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// Rev     : 1.0  initial release
// ============================================================================
module hex7seg
  import alu_seq_pkg::*;
(
  input  wire logic [3:0] nib,
  output logic      [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[0];
    case (nib)
      4'h0:    seg = SEG_TABLE[0];
      4'h1:    seg = SEG_TABLE[1];
      4'h2:    seg = SEG_TABLE[2];
      4'h3:    seg = SEG_TABLE[3];
      4'h4:    seg = SEG_TABLE[4];
      4'h5:    seg = SEG_TABLE[5];
      4'h6:    seg = SEG_TABLE[6];
      4'h7:    seg = SEG_TABLE[7];
      4'h8:    seg = SEG_TABLE[8];
      4'h9:    seg = SEG_TABLE[9];
      4'hA:    seg = SEG_TABLE[10];
      4'hB:    seg = SEG_TABLE[11];
      4'hC:    seg = SEG_TABLE[12];
      4'hD:    seg = SEG_TABLE[13];
      4'hE:    seg = SEG_TABLE[14];
      4'hF:    seg = SEG_TABLE[15];
      default: seg = SEG_TABLE[0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Purpose : Registered ALU with valid/ready request handshake. Single-cycle
//           ops complete at the accept edge; MUL runs as a W-step shift-add.
//           Result and {N,Z,V,C} flags are held and the result is decoded to
//           active-low seven-segment digits.
// Ports   : clk   in  rising-edge clock
//           rst   in  asynchronous active-high reset
//           bus   alu_seq_if.slave  (request handshake, operands, result,
//                 flags, hex digits)
// Rev     : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W    = 8,
  parameter int NDIG = W / 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_seq_if.slave   bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  // Architectural state
  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [W-1:0]     r_result;
  logic [3:0]       r_flags;
  logic             r_out_valid;

  // Multiplier state: r_prod low half starts as the multiplier and is
  // consumed one bit per step while the product grows into the high half.
  logic [W-1:0]     r_mcand;
  logic [2*W-1:0]   r_prod;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [W-1:0]     w_opa;
  logic [W-1:0]     w_opb;
  logic [W:0]       w_sum;
  logic [W:0]       w_diff;
  logic [W-1:0]     w_val;
  logic             w_wr;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;
  logic [W:0]       w_mstep;
  logic [2*W-1:0]   w_prod_next;
  logic             w_mul_last;
  logic             w_mul_hi;
  logic [7*NDIG-1:0] w_hex;

  // -------------------------------------------------------------------------
  // Operand selection and single-cycle datapath
  // -------------------------------------------------------------------------
  assign w_accept = bus.in_valid && w_in_ready;
  // Accumulator chaining reads the value held before the accept edge.
  assign w_opa    = bus.use_acc ? r_result : bus.a;
  assign w_opb    = ((bus.op == OP_INC) || (bus.op == OP_DEC)) ? W'(1) : bus.b;
  assign w_sum    = {1'b0, w_opa} + {1'b0, w_opb};
  // Top bit of the extended difference is the unsigned borrow.
  assign w_diff   = {1'b0, w_opa} - {1'b0, w_opb};

  always_comb begin
    w_val = w_opa;
    w_wr  = 1'b1;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_INC: begin
        w_val = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (w_opa[W-1] == w_opb[W-1]) && (w_sum[W-1] != w_opa[W-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        w_val = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (w_opa[W-1] != w_opb[W-1]) && (w_diff[W-1] != w_opa[W-1]);
        // CMP only reports flags; the held result stays untouched.
        w_wr  = (bus.op != OP_CMP);
      end
      OP_AND: w_val = w_opa & bus.b;
      OP_OR:  w_val = w_opa | bus.b;
      OP_XOR: w_val = w_opa ^ bus.b;
      OP_NOT: w_val = ~w_opa;
      OP_SHL: begin
        w_val = {w_opa[W-2:0], 1'b0};
        w_c   = w_opa[W-1];
      end
      OP_SHR: begin
        w_val = {1'b0, w_opa[W-1:1]};
        w_c   = w_opa[0];
      end
      OP_ASR: begin
        w_val = {w_opa[W-1], w_opa[W-1:1]};
        w_c   = w_opa[0];
      end
      default: w_val = w_opa;
    endcase
  end

  assign w_flags[FLAG_N] = w_val[W-1];
  assign w_flags[FLAG_Z] = (w_val == '0);
  assign w_flags[FLAG_V] = w_v;
  assign w_flags[FLAG_C] = w_c;

  // -------------------------------------------------------------------------
  // Shift-add multiply step
  // -------------------------------------------------------------------------
  assign w_mstep     = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_mstep, r_prod[W-1:1]};
  assign w_mul_last  = (r_cnt == CNT_W'(W - 1));
  assign w_mul_hi    = |w_prod_next[2*W-1:W];

  // -------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && (bus.op == OP_MUL)) w_state_next = ST_MULT;
      ST_MULT: if (w_mul_last)                     w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Result, flags and multiplier registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          if (bus.op == OP_MUL) begin
            r_mcand <= w_opa;
            r_prod  <= {{W{1'b0}}, bus.b};
            r_cnt   <= '0;
          end else begin
            if (w_wr) r_result <= w_val;
            r_flags     <= w_flags;
            r_out_valid <= 1'b1;
          end
        end
      end else begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_mul_last) begin
          r_result       <= w_prod_next[W-1:0];
          r_flags[FLAG_N] <= w_prod_next[W-1];
          r_flags[FLAG_Z] <= (w_prod_next[W-1:0] == '0);
          r_flags[FLAG_V] <= w_mul_hi;
          r_flags[FLAG_C] <= w_mul_hi;
          r_out_valid    <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Seven-segment digits, combinational from the held result
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    hex7seg u_hex7seg (
      .nib (r_result[4*gi+3:4*gi]),
      .seg (w_hex[7*gi+6:7*gi])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.hex       = w_hex;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq at W=8: directed vector table,
//           hand-written multi-cycle sequences, randomized ops against an
//           arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  localparam int W    = 8;
  localparam int NDIG = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.W(W), .NDIG(NDIG)) bus ();

  alu_seq #(.W(W), .NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_result;
  logic [3:0] m_flags;

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic [3:0] ef;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] hex_ref(input logic [7:0] v);
    return {seg_ref[v[7:4]], seg_ref[v[3:0]]};
  endfunction

  // Reference model from plain integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] r, output logic [3:0] f, output bit wr);
    int A, B, sA, sB, x, sx;
    bit c, v;
    A  = int'(av);
    B  = int'(bv);
    if (op == 4'h2 || op == 4'h3) B = 1;
    sA = (A >= 128) ? A - 256 : A;
    sB = (B >= 128) ? B - 256 : B;
    c  = 1'b0;
    v  = 1'b0;
    wr = 1'b1;
    x  = A;
    case (op)
      4'h0, 4'h3: begin
        x = A + B; sx = sA + sB;
        c = (x > 255); v = (sx > 127) || (sx < -128);
      end
      4'h1, 4'h2, 4'hC: begin
        x = A - B; sx = sA - sB;
        c = (A < B); v = (sx > 127) || (sx < -128);
        wr = (op != 4'hC);
      end
      4'h4: x = A & B;
      4'h5: x = A | B;
      4'h6: x = A ^ B;
      4'h7: x = 255 - A;
      4'h8: begin x = (A * 2) % 256; c = (A >= 128); end
      4'h9: begin x = A / 2; c = (A % 2) == 1; end
      4'hA: begin x = (sA - (A % 2)) / 2; c = (A % 2) == 1; end
      4'hB: begin x = A * B; c = (x > 255); v = c; end
      default: x = A;
    endcase
    r = 8'(x & 255);
    f = {r[7], (r == 8'h00), v, c};
  endtask

  // Issue a single-cycle op at a negedge; in_valid stays high afterwards so
  // consecutive calls are back-to-back accepts.
  task automatic do_single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic ua, input string name);
    logic [7:0] r;
    logic [3:0] f;
    bit wr;
    bus.op = op; bus.a = a; bus.b = b; bus.use_acc = ua; bus.in_valid = 1'b1;
    model(op, ua ? m_result : a, b, r, f, wr);
    @(posedge clk);
    @(negedge clk);
    m_flags = f;
    if (wr) m_result = r;
    check({name, "_valid"},  32'(bus.out_valid), 32'd1);
    check({name, "_result"}, 32'(bus.result),    32'(m_result));
    check({name, "_flags"},  32'(bus.flags),     32'(m_flags));
    check({name, "_hex"},    32'(bus.hex),       32'(hex_ref(m_result)));
    check({name, "_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic idle(input string name);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle_valid"},  32'(bus.out_valid), 32'd0);
    check({name, "_idle_result"}, 32'(bus.result),    32'(m_result));
    check({name, "_idle_flags"},  32'(bus.flags),     32'(m_flags));
  endtask

  // MUL with a competing request held during the busy window.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic ua, input string name);
    logic [7:0] r, old;
    logic [3:0] f;
    bit wr;
    int cyc;
    bit seen;
    bus.op = 4'hB; bus.a = a; bus.b = b; bus.use_acc = ua; bus.in_valid = 1'b1;
    model(4'hB, ua ? m_result : a, b, r, f, wr);
    old = m_result;
    @(posedge clk);
    @(negedge clk);
    bus.op = 4'h0; bus.a = 8'h11; bus.b = 8'h22; bus.use_acc = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < W + 4) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.in_ready !== 1'b0 || bus.result !== old) begin
        check({name, "_busy_ready"},  32'(bus.in_ready), 32'd0);
        check({name, "_busy_result"}, 32'(bus.result),   32'(old));
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({name, "_done"},    32'(seen), 32'd1);
    check({name, "_latency"}, 32'(cyc),  32'(W));
    m_result = r;
    m_flags  = f;
    check({name, "_result"}, 32'(bus.result),   32'(m_result));
    check({name, "_flags"},  32'(bus.flags),    32'(m_flags));
    check({name, "_ready"},  32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'hA};
    vecs[1]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'h5};
    vecs[2]  = '{4'h1, 8'h00, 8'h01, 8'hFF, 4'h9};
    vecs[3]  = '{4'hC, 8'h05, 8'h05, 8'hFF, 4'h4};
    vecs[4]  = '{4'hA, 8'h81, 8'h00, 8'hC0, 4'h9};
    vecs[5]  = '{4'h8, 8'h81, 8'h00, 8'h02, 4'h1};
    vecs[6]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 4'h2};
    vecs[7]  = '{4'h2, 8'h00, 8'h00, 8'hFF, 4'h9};
    vecs[8]  = '{4'h3, 8'h7F, 8'h00, 8'h80, 4'hA};
    vecs[9]  = '{4'h4, 8'hF0, 8'h3C, 8'h30, 4'h0};
    vecs[10] = '{4'h5, 8'hF0, 8'h0F, 8'hFF, 4'h8};
    vecs[11] = '{4'h6, 8'hAA, 8'hAA, 8'h00, 4'h4};
    vecs[12] = '{4'h7, 8'h55, 8'h00, 8'hAA, 4'h8};
    vecs[13] = '{4'h9, 8'h01, 8'h00, 8'h00, 4'h5};
    vecs[14] = '{4'hD, 8'h9A, 8'h00, 8'h9A, 4'h8};
    vecs[15] = '{4'hF, 8'h00, 8'h77, 8'h00, 4'h4};

    bus.in_valid = 1'b0;
    bus.op       = 4'h0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    bus.use_acc  = 1'b0;
    m_result     = 8'h00;
    m_flags      = 4'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_result", 32'(bus.result),    32'h00);
    check("rst_flags",  32'(bus.flags),     32'h0);
    check("rst_valid",  32'(bus.out_valid), 32'd0);
    check("rst_ready",  32'(bus.in_ready),  32'd1);
    check("rst_hex",    32'(bus.hex),       32'h2040);
    rst = 1'b0;
    idle("post_rst");

    // Directed vector table, applied back-to-back
    for (int i = 0; i < 16; i++) begin
      bus.op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
      bus.use_acc = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i),  32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(bus.result),    32'(vecs[i].er));
      check($sformatf("vec%0d_flags", i),  32'(bus.flags),     32'(vecs[i].ef));
      check($sformatf("vec%0d_hex", i),    32'(bus.hex),       32'(hex_ref(vecs[i].er)));
      m_result = vecs[i].er;
      m_flags  = vecs[i].ef;
    end
    idle("vec_end");

    // Hex glyphs after ASR / SHL
    do_single(4'hA, 8'h81, 8'h00, 1'b0, "asr");
    check("asr_hex_c0", 32'(bus.hex), 32'({7'h46, 7'h40}));
    do_single(4'h8, 8'h81, 8'h00, 1'b0, "shl");
    check("shl_hex_02", 32'(bus.hex), 32'({7'h40, 7'h24}));
    idle("hex");

    // Multiply corner cases
    do_mul(8'h10, 8'h10, 1'b0, "mul_ovf");
    check("mul_ovf_const_r", 32'(bus.result), 32'h00);
    check("mul_ovf_const_f", 32'(bus.flags),  32'h7);
    idle("mul_ovf");
    do_mul(8'h0F, 8'h03, 1'b0, "mul_small");
    check("mul_small_const_r", 32'(bus.result), 32'h2D);
    check("mul_small_const_f", 32'(bus.flags),  32'h0);
    idle("mul_small");
    do_mul(8'hFF, 8'h07, 1'b1, "mul_acc");
    idle("mul_acc");

    // Accumulator chaining
    do_single(4'hD, 8'h03, 8'h00, 1'b0, "chain_pass");
    do_single(4'h3, 8'hEE, 8'h00, 1'b1, "chain1");
    check("chain1_const", 32'(bus.result), 32'h04);
    do_single(4'h3, 8'hEE, 8'h00, 1'b1, "chain2");
    check("chain2_const", 32'(bus.result), 32'h05);
    do_single(4'h3, 8'hEE, 8'h00, 1'b1, "chain3");
    check("chain3_const", 32'(bus.result), 32'h06);
    idle("chain");

    // Randomized ops against the model
    for (int n = 0; n < 150; n++) begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      logic       rua;
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rua = 1'($urandom_range(0, 1));
      if (rop == 4'hB) begin
        do_mul(ra, rb, rua, $sformatf("rnd%0d_mul", n));
      end else begin
        do_single(rop, ra, rb, rua, $sformatf("rnd%0d_op%0h", n, rop));
      end
      if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d", n));
    end
    idle("rnd_end");

    // Reset mid-multiply aborts and clears asynchronously
    do_single(4'hD, 8'h9A, 8'h00, 1'b0, "pre_rst");
    bus.op = 4'hB; bus.a = 8'h10; bus.b = 8'h10; bus.use_acc = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_result", 32'(bus.result),    32'h00);
    check("mrst_flags",  32'(bus.flags),     32'h0);
    check("mrst_ready",  32'(bus.in_ready),  32'd1);
    check("mrst_valid",  32'(bus.out_valid), 32'd0);
    check("mrst_hex",    32'(bus.hex),       32'h2040);
    @(negedge clk);
    rst = 1'b0;
    m_result = 8'h00;
    m_flags  = 4'h0;
    idle("mrst");
    do_single(4'h0, 8'h12, 8'h34, 1'b0, "post_mrst_add");
    check("post_mrst_add_const", 32'(bus.result), 32'h46);
    idle("post_mrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
